fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 151 +++++++++++++++
 tb/tb_fetch_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch stage with a one-word registered output,
// decode back-pressure (STALL), halt/redirect control and optional accept counter.
// Optional feature macro: FETCH_PERF_CNT_EN builds the FetchCount accept counter;
// without it FetchCount is tied to zero.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_1000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] MemAddress,
    input  logic [31:0] MemInstruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    input  logic        OutReady,
    output logic        OutValid,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC,
    output logic [31:0] FetchCount
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // PC is kept word-aligned, so only bits [31:2] are stored.
    logic [29:0] pc_p0;
    logic [29:0] pc_nxt;
    logic        vld_p1;
    logic        vld_nxt;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic        accept;
    logic        fetch;

    // The two low bits of a redirect target are dropped by design.
    logic        unused_redirect_lsb;
    assign unused_redirect_lsb = ^RedirectPC[1:0];

    // Sequential PC increment: wraps to RESET_PC at PC_LIMIT or on 32-bit overflow.
    function automatic logic [29:0] pc_incr(input logic [29:0] pc);
        logic [30:0] sum;
        sum = {1'b0, pc} + 31'd1;
        if (sum[30] || ({sum[29:0], 2'b00} >= PC_LIMIT))
            pc_incr = RESET_PC[31:2];
        else
            pc_incr = sum[29:0];
    endfunction

    assign accept         = vld_p1 && OutReady;
    assign MemAddress     = {pc_p0, 2'b00};
    assign OutValid       = vld_p1;
    assign OutInstruction = instr_p1;
    assign OutPC          = pc_p1;

    // Next-state and fetch decision; Redirect wins over every state.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        vld_nxt   = vld_p1;
        fetch     = 1'b0;
        if (Redirect) begin
            pc_nxt    = RedirectPC[31:2];
            vld_nxt   = 1'b0;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (vld_p1 && !OutReady) begin
                        state_nxt = STALL;
                    end else if (Halt) begin
                        state_nxt = HALTED;
                        vld_nxt   = 1'b0;
                    end else begin
                        fetch = 1'b1;
                    end
                end
                STALL: begin
                    if (accept) begin
                        if (Halt) begin
                            state_nxt = HALTED;
                            vld_nxt   = 1'b0;
                        end else begin
                            state_nxt = RUN;
                            fetch     = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    vld_nxt = 1'b0;
                end
                default: begin
                    state_nxt = RUN;
                    vld_nxt   = 1'b0;
                end
            endcase
        end
        if (fetch) begin
            pc_nxt  = pc_incr(pc_p0);
            vld_nxt = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // PC and output register; the output word only changes on a fetch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_p0    <= RESET_PC[31:2];
            vld_p1   <= 1'b0;
            instr_p1 <= 32'd0;
            pc_p1    <= 32'd0;
        end else begin
            pc_p0  <= pc_nxt;
            vld_p1 <= vld_nxt;
            if (fetch) begin
                instr_p1 <= MemInstruction;
                pc_p1    <= {pc_p0, 2'b00};
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_p1;

    // Accept counter; an accept coinciding with a Redirect still counts.
    always_ff @(posedge Clk) begin
        if (Reset)
            cnt_p1 <= 32'd0;
        else if (accept)
            cnt_p1 <= cnt_p1 + 32'd1;
    end

    assign FetchCount = cnt_p1;
`else
    assign FetchCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and randomized bench for fetch_controller with a
// transaction-level reference model and a per-cycle expectation scoreboard.
module tb_fetch_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] LIMIT  = 32'h0000_1000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] MemAddress;
    logic [31:0] MemInstruction;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Halt;
    logic        OutReady;
    logic        OutValid;
    logic [31:0] OutInstruction;
    logic [31:0] OutPC;
    logic [31:0] FetchCount;

    always #5 Clk = ~Clk;

    // Instruction memory contents: word i holds i*3.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a >> 2) * 32'd3;
    endfunction

    assign MemInstruction = memf(MemAddress);

    fetch_controller #(.RESET_PC(RST_PC), .PC_LIMIT(LIMIT)) dut (
        .Clk(Clk), .Reset(Reset), .MemAddress(MemAddress), .MemInstruction(MemInstruction),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .Halt(Halt), .OutReady(OutReady),
        .OutValid(OutValid), .OutInstruction(OutInstruction), .OutPC(OutPC),
        .FetchCount(FetchCount)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the pending output word, the fetch pointer, a halted flag
    // and the number of accepted words.
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_opc;
    logic [31:0] m_ins;
    logic        m_halted;
    logic [31:0] m_cnt;

    typedef struct {
        logic        v;
        logic [31:0] opc;
        logic [31:0] ins;
        logic [31:0] addr;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    task automatic model(input logic r, input logic rd, input logic [31:0] rp,
                         input logic h, input logic rdy);
        logic [32:0] nx;
        exp_t e;
        if (r) begin
            m_pc = RST_PC & ~32'd3; m_v = 1'b0; m_opc = 0; m_ins = 0;
            m_halted = 1'b0; m_cnt = 0;
        end else begin
            if (m_v && rdy) m_cnt = m_cnt + 1;
            if (rd) begin
                m_pc = rp & ~32'd3; m_v = 1'b0; m_halted = 1'b0;
            end else if (m_halted) begin
                m_v = 1'b0;
            end else if (m_v && !rdy) begin
                // word waiting for decode: nothing moves
            end else if (h) begin
                m_halted = 1'b1; m_v = 1'b0;
            end else begin
                m_v = 1'b1; m_opc = m_pc; m_ins = memf(m_pc);
                nx = {1'b0, m_pc} + 33'd4;
                if (nx[32] || nx[31:0] >= LIMIT) m_pc = RST_PC & ~32'd3;
                else m_pc = nx[31:0];
            end
        end
        e.v = m_v; e.opc = m_opc; e.ins = m_ins; e.addr = m_pc;
`ifdef FETCH_PERF_CNT_EN
        e.cnt = m_cnt;
`else
        e.cnt = 32'd0;
`endif
        q.push_back(e);
    endtask

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input logic r, input logic rd, input logic [31:0] rp,
                        input logic h, input logic rdy);
        @(negedge Clk);
        #1;
        Reset = r; Redirect = rd; RedirectPC = rp; Halt = h; OutReady = rdy;
        @(posedge Clk);
        model(r, rd, rp, h, rdy);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("OutValid",       {31'd0, OutValid}, {31'd0, e.v});
            chk("OutPC",          OutPC,             e.opc);
            chk("OutInstruction", OutInstruction,    e.ins);
            chk("MemAddress",     MemAddress,        e.addr);
            chk("FetchCount",     FetchCount,        e.cnt);
        end
    end

    initial begin
        logic [31:0] rp;
        logic [31:0] cnt_exp;
        Reset = 1'b1; Redirect = 1'b0; RedirectPC = 32'd0; Halt = 1'b0; OutReady = 1'b0;
        m_pc = RST_PC; m_v = 1'b0; m_opc = 0; m_ins = 0; m_halted = 1'b0; m_cnt = 0;

        // Reset state
        step(1, 0, 0, 0, 0);
        chk("rst_valid", {31'd0, OutValid}, 32'd0);
        chk("rst_addr",  MemAddress, RST_PC);

        // Streaming fetch, one word per cycle
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            chk("stream_pc",  OutPC, 32'(i * 4));
            chk("stream_ins", OutInstruction, 32'(i * 3));
        end

        // Back-pressure hold at OutPC=8
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("stall_pc",   OutPC, 32'd8);
            chk("stall_ins",  OutInstruction, 32'd6);
            chk("stall_addr", MemAddress, 32'd12);
        end
        step(0, 0, 0, 0, 1);
        chk("release_pc", OutPC, 32'd12);

        // Redirect while stalled, unaligned target
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h43, 0, 0);
        chk("redir_valid", {31'd0, OutValid}, 32'd0);
        chk("redir_addr",  MemAddress, 32'h40);
        step(0, 0, 0, 0, 1);
        chk("redir_pc", OutPC, 32'h40);

        // Wrap at PC_LIMIT
        step(0, 1, 32'hFF8, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("wrap_pc0", OutPC, 32'hFF8);
        step(0, 0, 0, 0, 1);
        chk("wrap_pc1",  OutPC, 32'hFFC);
        chk("wrap_addr", MemAddress, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("wrap_pc2", OutPC, 32'h0);

        // Halt requested while stalled
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("halt_hold_valid", {31'd0, OutValid}, 32'd1);
        step(0, 0, 0, 1, 1);
        chk("halt_valid", {31'd0, OutValid}, 32'd0);
        chk("halt_addr",  MemAddress, 32'h4);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("halted_valid", {31'd0, OutValid}, 32'd0);
        chk("halted_addr",  MemAddress, 32'h4);
        step(0, 1, 32'h20, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("resume_pc",    OutPC, 32'h20);
        chk("resume_valid", {31'd0, OutValid}, 32'd1);

        // Accept counter: ten accepts, the tenth coinciding with a Redirect
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 32'h100, 0, 1);
`ifdef FETCH_PERF_CNT_EN
        cnt_exp = 32'd10;
`else
        cnt_exp = 32'd0;
`endif
        chk("count_10", FetchCount, cnt_exp);
        step(1, 1, 32'h200, 1, 1);
        chk("count_rst",  FetchCount, 32'd0);
        chk("rst_over_redirect", MemAddress, RST_PC);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rp = $urandom();
            else rp = $urandom_range(0, 32'h1010);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 19) == 0,
                 rp,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge Clk);
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
